// File: rtl/lookup_engine_mt.sv
// lookup_engine_mt: pipelined multi-tenant ternary match table
// with valid/ready backpressure and saturating hit/miss counters.
module lookup_engine_mt #(
    parameter int STAGE      = 0,
    parameter int KEY_LEN    = 896,
    parameter int PHV_LEN    = 1579,
    parameter int ACTION_LEN = 25,
    parameter int DEPTH      = 16,
    parameter int TENANT_W   = 4,
    parameter int TENANT_LSB = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    input  logic [KEY_LEN-1:0]    extract_key,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic                  cond_flag,
    input  logic [PHV_LEN-1:0]    pkt_hdr_vec,
    output logic [ACTION_LEN-1:0] action,
    output logic                  action_hit,
    output logic                  action_valid,
    input  logic                  action_ready,
    output logic [PHV_LEN-1:0]    pkt_hdr_vec_out,
    input  logic [KEY_LEN-1:0]    lookup_din,
    input  logic [KEY_LEN-1:0]    lookup_din_mask,
    input  logic [TENANT_W-1:0]   lookup_din_tenant,
    input  logic                  lookup_din_vld,
    input  logic [AW-1:0]         lookup_din_addr,
    input  logic                  lookup_din_en,
    input  logic [ACTION_LEN-1:0] action_data_in,
    input  logic [AW-1:0]         action_addr,
    input  logic                  action_en,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    // STAGE only labels the instance; no logic depends on it.
    if (STAGE < 0) begin : g_stage_label
    end

    logic [KEY_LEN-1:0]    key_q  [DEPTH];
    logic [KEY_LEN-1:0]    key_d  [DEPTH];
    logic [KEY_LEN-1:0]    mask_q [DEPTH];
    logic [KEY_LEN-1:0]    mask_d [DEPTH];
    logic [TENANT_W-1:0]   ten_q  [DEPTH];
    logic [TENANT_W-1:0]   ten_d  [DEPTH];
    logic [ACTION_LEN-1:0] act_q  [DEPTH];
    logic [ACTION_LEN-1:0] act_d  [DEPTH];
    logic [DEPTH-1:0]      vld_q, vld_d;

    logic                  s0_vld_q, s0_vld_d;
    logic [KEY_LEN-1:0]    s0_key_q, s0_key_d;
    logic [PHV_LEN-1:0]    s0_phv_q, s0_phv_d;
    logic                  s0_cond_q, s0_cond_d;
    logic [TENANT_W-1:0]   s0_ten_q, s0_ten_d;

    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_hit_q, s1_hit_d;
    logic                  s1_byp_q, s1_byp_d;
    logic [AW-1:0]         s1_idx_q, s1_idx_d;
    logic [PHV_LEN-1:0]    s1_phv_q, s1_phv_d;

    logic                  out_vld_q, out_vld_d;
    logic                  out_hit_q, out_hit_d;
    logic                  out_byp_q, out_byp_d;
    logic [ACTION_LEN-1:0] out_act_q, out_act_d;
    logic [PHV_LEN-1:0]    out_phv_q, out_phv_d;

    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;

    logic                  adv;
    logic                  fire;
    logic                  match_hit;
    logic [AW-1:0]         match_idx;
    logic                  ent_ok;
    logic                  act_ok;

    assign adv    = ~out_vld_q | action_ready;
    assign fire   = out_vld_q & action_ready;
    assign ent_ok = 32'(lookup_din_addr) < 32'(DEPTH);
    assign act_ok = 32'(action_addr) < 32'(DEPTH);

    always_comb begin
        key_d  = key_q;
        mask_d = mask_q;
        ten_d  = ten_q;
        vld_d  = vld_q;
        act_d  = act_q;
        if (lookup_din_en && ent_ok) begin
            key_d[lookup_din_addr]  = lookup_din;
            mask_d[lookup_din_addr] = lookup_din_mask;
            ten_d[lookup_din_addr]  = lookup_din_tenant;
            vld_d[lookup_din_addr]  = lookup_din_vld;
        end
        if (action_en && act_ok) begin
            act_d[action_addr] = action_data_in;
        end
    end

    // Walk from the top so the lowest matching index is left standing.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && (((s0_key_q ^ key_q[i]) & mask_q[i]) == '0)
                && (ten_q[i] == s0_ten_q)) begin
                match_hit = 1'b1;
                match_idx = AW'(i);
            end
        end
    end

    always_comb begin
        s0_vld_d  = s0_vld_q;
        s0_key_d  = s0_key_q;
        s0_phv_d  = s0_phv_q;
        s0_cond_d = s0_cond_q;
        s0_ten_d  = s0_ten_q;
        s1_vld_d  = s1_vld_q;
        s1_hit_d  = s1_hit_q;
        s1_byp_d  = s1_byp_q;
        s1_idx_d  = s1_idx_q;
        s1_phv_d  = s1_phv_q;
        out_vld_d = out_vld_q;
        out_hit_d = out_hit_q;
        out_byp_d = out_byp_q;
        out_act_d = out_act_q;
        out_phv_d = out_phv_q;
        if (adv) begin
            s0_vld_d  = key_valid;
            s0_key_d  = extract_key;
            s0_phv_d  = pkt_hdr_vec;
            s0_cond_d = cond_flag;
            s0_ten_d  = pkt_hdr_vec[TENANT_LSB +: TENANT_W];
            s1_vld_d  = s0_vld_q;
            s1_hit_d  = s0_cond_q & match_hit;
            s1_byp_d  = ~s0_cond_q;
            s1_idx_d  = match_idx;
            s1_phv_d  = s0_phv_q;
            out_vld_d = s1_vld_q;
            out_hit_d = s1_hit_q;
            out_byp_d = s1_byp_q;
            out_act_d = s1_hit_q ? act_q[s1_idx_q] : '0;
            out_phv_d = s1_phv_q;
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (fire && !out_byp_q) begin
            if (out_hit_q && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!out_hit_q && miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]  <= '0;
                mask_q[i] <= '0;
                ten_q[i]  <= '0;
                act_q[i]  <= '0;
            end
            vld_q      <= '0;
            s0_vld_q   <= 1'b0;
            s0_key_q   <= '0;
            s0_phv_q   <= '0;
            s0_cond_q  <= 1'b0;
            s0_ten_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_phv_q   <= '0;
            out_vld_q  <= 1'b0;
            out_hit_q  <= 1'b0;
            out_byp_q  <= 1'b0;
            out_act_q  <= '0;
            out_phv_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            key_q      <= key_d;
            mask_q     <= mask_d;
            ten_q      <= ten_d;
            act_q      <= act_d;
            vld_q      <= vld_d;
            s0_vld_q   <= s0_vld_d;
            s0_key_q   <= s0_key_d;
            s0_phv_q   <= s0_phv_d;
            s0_cond_q  <= s0_cond_d;
            s0_ten_q   <= s0_ten_d;
            s1_vld_q   <= s1_vld_d;
            s1_hit_q   <= s1_hit_d;
            s1_byp_q   <= s1_byp_d;
            s1_idx_q   <= s1_idx_d;
            s1_phv_q   <= s1_phv_d;
            out_vld_q  <= out_vld_d;
            out_hit_q  <= out_hit_d;
            out_byp_q  <= out_byp_d;
            out_act_q  <= out_act_d;
            out_phv_q  <= out_phv_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign key_ready       = adv;
    assign action          = out_act_q;
    assign action_hit      = out_hit_q;
    assign action_valid    = out_vld_q;
    assign pkt_hdr_vec_out = out_phv_q;
    assign hit_cnt         = hit_cnt_q;
    assign miss_cnt        = miss_cnt_q;

endmodule
